// File: rtl/vend_pkg.sv
// Shared constants and helpers for the coin-operated vending controller.
package vend_pkg;

   localparam int unsigned COIN1_VAL = 1;
   localparam int unsigned COIN2_VAL = 2;
   localparam int unsigned COIN5_VAL = 5;
   localparam int unsigned MAX_ADD   = COIN1_VAL + COIN2_VAL + COIN5_VAL;
   localparam int unsigned ADD_W     = $clog2(MAX_ADD + 1);

   // Minimum credit width able to hold PRICE-1 plus the largest single-edge add.
   function automatic int unsigned credit_width(input int unsigned price);
      return $clog2(price + MAX_ADD);
   endfunction

endpackage

// File: rtl/vend_coin_adder.sv
// Combinational encoder turning the three coin strobes into a yuan value.
module vend_coin_adder
   import vend_pkg::*;
(
   input  logic             coin1,
   input  logic             coin2,
   input  logic             coin5,
   output logic [ADD_W-1:0] add
);

   // Simultaneous strobes are summed rather than prioritised.
   always_comb begin
      add = '0;
      if (coin1) add = add + ADD_W'(COIN1_VAL);
      if (coin2) add = add + ADD_W'(COIN2_VAL);
      if (coin5) add = add + ADD_W'(COIN5_VAL);
   end

endmodule

// File: rtl/vlg_design_vending.sv
// Vending controller top: credit register, price compare and the done pulse.
// Build option VEND_CARRY_CREDIT_EN keeps excess credit after a purchase.
module vlg_design_vending
   import vend_pkg::*;
#(
   parameter int unsigned PRICE = 5,
   parameter int unsigned CW    = 6
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_1yuan,
   input  logic i_2yuan,
   input  logic i_5yuan,
   output logic o_done
);

   logic [ADD_W-1:0] add;
   logic [CW-1:0]    credit;
   logic [CW-1:0]    credit_nxt;
   logic [CW-1:0]    sum;
   logic             dispense;

   vend_coin_adder u_coin_adder (
      .coin1 (i_1yuan),
      .coin2 (i_2yuan),
      .coin5 (i_5yuan),
      .add   (add)
   );

   // Credit register doubles as the IDLE/COLLECT state; at most one item per edge.
   always_comb begin
      sum        = credit + CW'(add);
      dispense   = (sum >= CW'(PRICE));
      credit_nxt = sum;
      if (dispense) begin
`ifdef VEND_CARRY_CREDIT_EN
         credit_nxt = sum - CW'(PRICE);
`else
         credit_nxt = '0;
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         credit <= '0;
         o_done <= 1'b0;
      end else begin
         credit <= credit_nxt;
         o_done <= dispense;
      end
   end

endmodule

// File: tb/tb_vlg_design_vending.sv
// Scoreboard bench for vlg_design_vending (PRICE=5), both credit build options.
module tb_vlg_design_vending;

   localparam int unsigned PRICE = 5;

   typedef struct {
      string tag;
      bit    done;
   } exp_t;

   logic clk = 1'b0;
   logic i_rst_n = 1'b0;
   logic i_1yuan = 1'b0;
   logic i_2yuan = 1'b0;
   logic i_5yuan = 1'b0;
   logic o_done;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   credit_m = 0;

   vlg_design_vending #(.PRICE(PRICE), .CW(6)) dut (
      .i_clk   (clk),
      .i_rst_n (i_rst_n),
      .i_1yuan (i_1yuan),
      .i_2yuan (i_2yuan),
      .i_5yuan (i_5yuan),
      .o_done  (o_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: o_done=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive one edge of stimulus, predict o_done, then compare after the edge.
   task automatic step(input string tag, input bit c1, input bit c2, input bit c5,
                       input bit rst);
      exp_t e;
      int   sum;
      @(negedge clk);
      i_1yuan = c1;
      i_2yuan = c2;
      i_5yuan = c5;
      i_rst_n = ~rst;
      e.tag  = tag;
      e.done = 1'b0;
      if (rst) begin
         credit_m = 0;
      end else begin
         sum = credit_m + (c1 ? 1 : 0) + (c2 ? 2 : 0) + (c5 ? 5 : 0);
         if (sum >= int'(PRICE)) begin
            e.done = 1'b1;
`ifdef VEND_CARRY_CREDIT_EN
            credit_m = sum - int'(PRICE);
`else
            credit_m = 0;
`endif
         end else begin
            credit_m = sum;
         end
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 1'bx, 1'b0);
      end else begin
         e = sb.pop_front();
         check(e.tag, o_done, e.done);
      end
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step("reset", 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      int r;
      // 1) long reset with coins strobing, then a lone 1-yuan coin
      for (int i = 0; i < 100; i++) begin
         r = int'($urandom_range(0, 7));
         step("rst_hold", r[0], r[1], r[2], 1'b1);
      end
      step("after_rst_1", 1'b1, 1'b0, 1'b0, 1'b0);
      idle("after_rst_idle");

      // 2) single 5-yuan coin
      do_reset();
      step("coin5", 1'b0, 1'b0, 1'b1, 1'b0);
      idle("coin5_pulse_end");
      idle("coin5_idle");

      // 3) 1,2,2
      do_reset();
      step("seq122_a", 1'b1, 1'b0, 1'b0, 1'b0);
      step("seq122_b", 1'b0, 1'b1, 1'b0, 1'b0);
      step("seq122_c", 1'b0, 1'b1, 1'b0, 1'b0);
      idle("seq122_end");

      // 4) 2,2,2 then 2,2 (carry-dependent)
      do_reset();
      for (int i = 0; i < 5; i++) step($sformatf("seq22222_%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
      idle("seq22222_end");

      // 5) all three coins at once, then a 2 to probe the residue
      do_reset();
      step("all3", 1'b1, 1'b1, 1'b1, 1'b0);
      idle("all3_gap");
      step("all3_probe2", 1'b0, 1'b1, 1'b0, 1'b0);
      idle("all3_end");

      // back-to-back 5s give consecutive pulses
      do_reset();
      step("b2b_a", 1'b0, 1'b0, 1'b1, 1'b0);
      step("b2b_b", 1'b0, 1'b0, 1'b1, 1'b0);
      idle("b2b_end");

      // 6) random coin sequence against the model
      do_reset();
      for (int i = 0; i < 20; i++) begin
         r = int'($urandom_range(0, 6));
         case (r)
            0, 1:    step("rand", 1'b1, 1'b0, 1'b0, 1'b0);
            2, 3:    step("rand", 1'b0, 1'b1, 1'b0, 1'b0);
            4:       step("rand", 1'b0, 1'b0, 1'b1, 1'b0);
            5:       step("rand", 1'b1, 1'b1, 1'b0, 1'b0);
            default: step("rand", 1'b1, 1'b1, 1'b1, 1'b0);
         endcase
         if ($urandom_range(0, 1) == 0) idle("rand_idle");
      end

      // reset mid-purchase discards credit
      do_reset();
      step("lost_a", 1'b0, 1'b1, 1'b0, 1'b0);
      step("lost_b", 1'b0, 1'b1, 1'b0, 1'b0);
      do_reset();
      step("lost_1", 1'b1, 1'b0, 1'b0, 1'b0);
      idle("lost_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
